// File: rtl/jaxis_video_master.sv
// Camera-style pixel bus (frame_valid/line_valid/rgb24_valid) to AXI4-Stream video master.
// tuser marks the first pixel of a frame, tlast the last pixel of a line; a small FIFO absorbs backpressure.
module jaxis_video_master #(
    parameter int DW            = 8,
    parameter int SENSOR_X_SIZE = 720,
    parameter int SENSOR_Y_SIZE = 720,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [2:0][DW-1:0]               rgb24,
    input  logic                             rgb24_valid,
    input  logic                             frame_valid,
    input  logic                             line_valid,
    input  logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_m1,
    input  logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_m1,
    output logic [3*DW-1:0]                  m_axis_video_tdata,
    output logic                             m_axis_video_tvalid,
    input  logic                             m_axis_video_tready,
    output logic                             m_axis_video_tuser,
    output logic                             m_axis_video_tlast,
    output logic                             overflow,
    output logic                             line_err,
    output logic                             frame_done,
    output logic [1:0]                       dbg_state
);

    localparam int XW = $clog2(SENSOR_X_SIZE);
    localparam int YW = $clog2(SENSOR_Y_SIZE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 * DW + 2;

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_ACTIVE   = 2'd1,
        S_DROP     = 2'd2
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x_cnt;
    logic [YW-1:0]   r_y_cnt;
    logic            r_sof_pend;
    logic            r_line_done;
    logic            r_fv;
    logic            r_lv;
    logic            r_overflow;
    logic            r_line_err;
    logic            r_frame_done;

    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_tvalid;
    logic            r_tuser;
    logic            r_tlast;
    logic [3*DW-1:0] r_tdata;

    logic            w_acc;
    logic            w_fv_rise;
    logic            w_fv_fall;
    logic            w_lv_fall;
    logic            w_run;
    logic [XW-1:0]   w_x;
    logic [YW-1:0]   w_y;
    logic            w_sof;
    logic            w_line_done;
    logic            w_last;
    logic            w_want;
    logic            w_long;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_ovf;
    logic [EW-1:0]   w_din;
    logic [AW-1:0]   w_rd_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_remain;
    logic [EW-1:0]   w_head_nxt;

    assign w_acc     = rgb24_valid & frame_valid & line_valid;
    assign w_fv_rise = frame_valid & ~r_fv;
    assign w_fv_fall = ~frame_valid & r_fv;
    assign w_lv_fall = r_lv & ~line_valid;

    // A frame_valid rising edge restarts the frame in the same cycle, so a pixel
    // arriving on that edge already sees cleared counters and a pending SOF.
    assign w_run       = w_fv_rise | (r_state == S_ACTIVE);
    assign w_x         = w_fv_rise ? '0 : r_x_cnt;
    assign w_y         = w_fv_rise ? '0 : r_y_cnt;
    assign w_sof       = w_fv_rise | r_sof_pend;
    assign w_line_done = w_fv_rise ? 1'b0 : r_line_done;
    assign w_last      = (w_x == x_size_m1);

    assign w_want = w_run & w_acc & ~w_line_done;
    assign w_long = w_run & w_acc & w_line_done;

    // AXIS handshake: a beat transfers on a rising clk edge where tvalid and tready
    // are both high; tvalid never depends on tready, and the head is held until taken.
    assign w_pop  = r_tvalid & m_axis_video_tready;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_push = w_want & (~w_full | w_pop);
    assign w_ovf  = w_want & w_full & ~w_pop;

    assign w_din      = {w_sof, w_last, rgb24};
    assign w_rd_nxt   = r_rd_ptr + AW'(w_pop);
    assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_remain   = r_count - CW'(w_pop);
    // When the FIFO drains to zero this cycle the incoming pixel becomes the head directly.
    assign w_head_nxt = (w_remain == '0) ? w_din : r_mem[w_rd_nxt];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_WAIT_SOF;
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_sof_pend   <= 1'b0;
            r_line_done  <= 1'b0;
            r_fv         <= 1'b1;
            r_lv         <= 1'b0;
            r_overflow   <= 1'b0;
            r_line_err   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_fv         <= frame_valid;
            r_lv         <= line_valid;
            r_frame_done <= 1'b0;
            if (w_long) begin
                r_line_err <= 1'b1;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
                r_state    <= S_DROP;
            end else if (w_push) begin
                r_sof_pend <= 1'b0;
                if (w_last) begin
                    r_x_cnt     <= '0;
                    r_line_done <= 1'b1;
                    if (w_y == y_size_m1) begin
                        r_y_cnt      <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_WAIT_SOF;
                    end else begin
                        r_y_cnt <= w_y + 1'b1;
                        r_state <= S_ACTIVE;
                    end
                end else begin
                    r_x_cnt     <= w_x + 1'b1;
                    r_y_cnt     <= w_y;
                    r_line_done <= 1'b0;
                    r_state     <= S_ACTIVE;
                end
            end else if (w_fv_rise) begin
                r_state     <= S_ACTIVE;
                r_sof_pend  <= 1'b1;
                r_x_cnt     <= '0;
                r_y_cnt     <= '0;
                r_line_done <= 1'b0;
            end else if (r_state == S_ACTIVE) begin
                if (w_fv_fall) begin
                    r_state <= S_WAIT_SOF;
                    if (r_x_cnt != '0 || r_y_cnt != '0) begin
                        r_line_err <= 1'b1;
                    end
                end else if (w_lv_fall) begin
                    r_line_done <= 1'b0;
                    if (r_x_cnt != '0) begin
                        r_line_err <= 1'b1;
                        r_x_cnt    <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_tvalid <= (w_cnt_nxt != '0);
            if (w_cnt_nxt != '0) begin
                {r_tuser, r_tlast, r_tdata} <= w_head_nxt;
            end
        end
    end

    assign m_axis_video_tdata  = r_tdata;
    assign m_axis_video_tvalid = r_tvalid;
    assign m_axis_video_tuser  = r_tuser;
    assign m_axis_video_tlast  = r_tlast;
    assign overflow            = r_overflow;
    assign line_err            = r_line_err;
    assign frame_done          = r_frame_done;
    assign dbg_state           = r_state;

endmodule

// File: tb/tb_jaxis_video_master.sv
// Directed bench for jaxis_video_master: expected AXIS beats are built per frame from
// the line/frame rules and checked by a scoreboard on every handshake.
module tb_jaxis_video_master;

  localparam int DW = 8;
  localparam int W  = 3 * DW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [2:0][DW-1:0] rgb24;
  logic             rgb24_valid;
  logic             frame_valid;
  logic             line_valid;
  logic [9:0]       x_size_m1;
  logic [9:0]       y_size_m1;
  logic [3*DW-1:0]  tdata;
  logic             tvalid;
  logic             tready;
  logic             tuser;
  logic             tlast;
  logic             overflow;
  logic             line_err;
  logic             frame_done;
  logic [1:0]       dbg_state;

  jaxis_video_master #(
    .DW(DW), .SENSOR_X_SIZE(720), .SENSOR_Y_SIZE(720), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rgb24(rgb24),
    .rgb24_valid(rgb24_valid),
    .frame_valid(frame_valid),
    .line_valid(line_valid),
    .x_size_m1(x_size_m1),
    .y_size_m1(y_size_m1),
    .m_axis_video_tdata(tdata),
    .m_axis_video_tvalid(tvalid),
    .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser),
    .m_axis_video_tlast(tlast),
    .overflow(overflow),
    .line_err(line_err),
    .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;
  int fd_cnt = 0;
  logic [7:0] k = 8'd0;
  logic [W-1:0] exp_q[$];
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_beat = '0;
  logic tog_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3*DW-1:0] pix_data(input logic [7:0] kk);
    return {kk + 8'h80, kk + 8'h40, kk};
  endfunction

  task automatic exp_push(input logic u, input logic l, input logic [3*DW-1:0] d);
    exp_q.push_back({u, l, d});
  endtask

  // n pixels of a line of width w starting at pixel index k0
  task automatic exp_line(input logic [7:0] k0, input int n, input int w, input logic first_user);
    for (int i = 0; i < n; i++)
      exp_push(first_user && (i == 0), i == (w - 1), pix_data(k0 + 8'(i)));
  endtask

  // clock/reset and driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix();
    rgb24[0] = k;
    rgb24[1] = k + 8'h40;
    rgb24[2] = k + 8'h80;
    rgb24_valid = 1'b1;
    tick();
    rgb24_valid = 1'b0;
    k = k + 8'd1;
  endtask

  task automatic send_line(input int n);
    line_valid = 1'b1;
    repeat (n) pix();
    line_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic start_frame();
    frame_valid = 1'b0;
    repeat (2) tick();
    frame_valid = 1'b1;
    repeat (2) tick();
  endtask

  task automatic end_frame();
    frame_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    chk({name, "_left"}, exp_q.size(), 0);
    repeat (3) tick();
    chk({name, "_idle_tvalid"}, tvalid, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (tog_en) tready = ~tready;
  end

  // scoreboard: stability under stall, and every handshake against the expected queue
  always @(negedge clk) begin
    logic [W-1:0] beat;
    beat = {tuser, tlast, tdata};
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (prev_stall) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_beat", beat, prev_beat);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h expected none", beat);
        end else begin
          chk("beat", beat, exp_q.pop_front());
        end
      end
      prev_stall = tvalid && !tready;
      prev_beat = beat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    logic [7:0] k0;
    resetn = 1'b0;
    rgb24 = '0;
    rgb24_valid = 1'b0;
    frame_valid = 1'b0;
    line_valid = 1'b0;
    tready = 1'b1;
    x_size_m1 = 10'd3;
    y_size_m1 = 10'd1;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_state", dbg_state, 0);
    resetn = 1'b1;
    tick();

    // 4x2 frame, tready high; literal beats pin component order and markers
    fd0 = fd_cnt;
    exp_push(1, 0, 24'h804000);
    exp_push(0, 0, 24'h814101);
    exp_push(0, 0, 24'h824202);
    exp_push(0, 1, 24'h834303);
    exp_push(0, 0, 24'h844404);
    exp_push(0, 0, 24'h854505);
    exp_push(0, 0, 24'h864606);
    exp_push(0, 1, 24'h874707);
    start_frame();
    send_line(4);
    send_line(4);
    end_frame();
    drain("t1");
    chk("t1_frame_done", fd_cnt - fd0, 1);
    chk("t1_overflow", overflow, 0);
    chk("t1_line_err", line_err, 0);
    chk("t1_state", dbg_state, 0);

    // same frame with tready toggling every cycle
    fd0 = fd_cnt;
    k0 = k;
    exp_line(k0, 4, 4, 1);
    exp_line(k0 + 8'd4, 4, 4, 0);
    tog_en = 1'b1;
    start_frame();
    send_line(4);
    send_line(4);
    end_frame();
    drain("t2");
    tog_en = 1'b0;
    tick();
    tready = 1'b1;
    chk("t2_frame_done", fd_cnt - fd0, 1);
    chk("t2_overflow", overflow, 0);

    // overflow: 32-pixel line into a 16-deep FIFO with tready low
    x_size_m1 = 10'd31;
    y_size_m1 = 10'd1;
    tready = 1'b0;
    k0 = k;
    exp_line(k0, 16, 32, 1);
    start_frame();
    line_valid = 1'b1;
    repeat (16) pix();
    chk("t3_no_ovf_16", overflow, 0);
    pix();
    chk("t3_ovf_17", overflow, 1);
    chk("t3_state_drop", dbg_state, 2);
    repeat (15) pix();
    line_valid = 1'b0;
    repeat (2) tick();
    send_line(32);
    end_frame();
    chk("t3_still_drop", dbg_state, 2);
    tready = 1'b1;
    drain("t3a");
    fd0 = fd_cnt;
    x_size_m1 = 10'd3;
    y_size_m1 = 10'd0;
    k0 = k;
    exp_line(k0, 4, 4, 1);
    start_frame();
    send_line(4);
    end_frame();
    drain("t3b");
    chk("t3_frame_done", fd_cnt - fd0, 1);
    chk("t3_ovf_sticky", overflow, 1);

    // short line 0, full line 1
    x_size_m1 = 10'd3;
    y_size_m1 = 10'd1;
    chk("t4_line_err_pre", line_err, 0);
    fd0 = fd_cnt;
    k0 = k;
    exp_line(k0, 3, 4, 1);
    exp_line(k0 + 8'd3, 4, 4, 0);
    start_frame();
    send_line(3);
    chk("t4_line_err", line_err, 1);
    send_line(4);
    end_frame();
    drain("t4");
    chk("t4_frame_done", fd_cnt - fd0, 0);
    chk("t4_state", dbg_state, 0);

    // one-cycle reset mid-line with 5 beats queued
    x_size_m1 = 10'd7;
    y_size_m1 = 10'd1;
    tready = 1'b0;
    start_frame();
    line_valid = 1'b1;
    repeat (5) pix();
    resetn = 1'b0;
    rgb24_valid = 1'b1;
    tick();
    resetn = 1'b1;
    rgb24_valid = 1'b0;
    exp_q.delete();
    chk("t6_tvalid", tvalid, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_line_err", line_err, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_state", dbg_state, 0);
    tready = 1'b1;
    repeat (4) pix();
    chk("t6_ignored_tvalid", tvalid, 0);
    chk("t6_ignored_state", dbg_state, 0);
    line_valid = 1'b0;
    end_frame();
    fd0 = fd_cnt;
    x_size_m1 = 10'd3;
    y_size_m1 = 10'd0;
    k0 = k;
    exp_line(k0, 4, 4, 1);
    start_frame();
    send_line(4);
    end_frame();
    drain("t6");
    chk("t6_frame_done_new", fd_cnt - fd0, 1);

    // frame_valid drops after line 0 of a 2-line frame
    x_size_m1 = 10'd3;
    y_size_m1 = 10'd1;
    chk("t5_line_err_pre", line_err, 0);
    fd0 = fd_cnt;
    k0 = k;
    exp_line(k0, 4, 4, 1);
    start_frame();
    send_line(4);
    end_frame();
    chk("t5_line_err", line_err, 1);
    chk("t5_state", dbg_state, 0);
    y_size_m1 = 10'd0;
    k0 = k;
    exp_line(k0, 4, 4, 1);
    start_frame();
    send_line(4);
    end_frame();
    drain("t5");
    chk("t5_frame_done", fd_cnt - fd0, 1);

    // long line: 6 pixels for a 4-wide line, extras dropped
    do_reset();
    x_size_m1 = 10'd3;
    y_size_m1 = 10'd1;
    tick();
    chk("t7_line_err_pre", line_err, 0);
    fd0 = fd_cnt;
    k0 = k;
    exp_line(k0, 4, 4, 1);
    exp_line(k0 + 8'd6, 4, 4, 0);
    start_frame();
    send_line(6);
    chk("t7_line_err", line_err, 1);
    send_line(4);
    end_frame();
    drain("t7");
    chk("t7_frame_done", fd_cnt - fd0, 1);
    chk("t7_state", dbg_state, 0);
    chk("t7_overflow", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jaxis_video_master.md
Name: jaxis_video_master

Overview:
Converts the encoder-side camera-style pixel bus (frame_valid / line_valid / rgb24_valid) into an AXI4-Stream video master.
- tuser marks start of frame (SOF); tlast marks end of line (EOL).
- A small FIFO absorbs AXIS backpressure, because the source bus has no stall.
- Used for loopback, test-pattern output and debug taps alongside the AXIS JPEG encoder.

Parameters:
DW, 8, bits per colour component
SENSOR_X_SIZE, 720, maximum line width in pixels; sizes x counter
SENSOR_Y_SIZE, 720, maximum frame height in lines; sizes y counter
FIFO_DEPTH, 16, output FIFO entries; power of 2, >= 4

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
rgb24  in  3x DW  pixel components [0]=R, [1]=G, [2]=B
rgb24_valid  in  1  pixel strobe
frame_valid  in  1  frame active level
line_valid  in  1  line active level
x_size_m1  in  $clog2(SENSOR_X_SIZE)  active width - 1
y_size_m1  in  $clog2(SENSOR_Y_SIZE)  active height - 1
m_axis_video_tdata  out  3*DW  {B,G,R}
m_axis_video_tvalid  out  1  beat valid
m_axis_video_tready  in  1  downstream ready
m_axis_video_tuser  out  1  SOF, first pixel of frame
m_axis_video_tlast  out  1  EOL, last pixel of line
overflow  out  1  sticky: pixel dropped due to full FIFO
line_err  out  1  sticky: line length != x_size_m1+1
frame_done  out  1  one-cycle pulse when final tlast of the frame is pushed

Behaviour:
- Reset: FIFO empty; tvalid=0; tuser=0; tlast=0; tdata=0; overflow=0; line_err=0; frame_done=0; FSM=WAIT_SOF; x_cnt=0; y_cnt=0. A reset mid-frame discards all FIFO content and in-flight state.
- Pixel accept: acc = rgb24_valid & frame_valid & line_valid. Pixels arriving outside frame_valid & line_valid are ignored.
- FSM:
  - WAIT_SOF: wait for frame_valid low, then high (rising edge detected with a registered frame_valid) -> ACTIVE. Set sof_pend=1, x_cnt=0, y_cnt=0.
  - ACTIVE:
    - Each acc pushes {tuser=sof_pend, tlast=(x_cnt==x_size_m1), pixel}, then clears sof_pend.
    - x_cnt increments; it clears to 0 on tlast.
    - On tlast, y_cnt increments; if y_cnt==y_size_m1, pulse frame_done and go to WAIT_SOF.
  - DROP: entered on overflow. Discard every pixel until the next frame_valid rising edge -> ACTIVE (same init as from WAIT_SOF).
- Frame start: a frame_valid rising edge in any state starts a new frame (sof_pend=1, counters cleared).
- Frame end: frame_valid falling while in ACTIVE -> WAIT_SOF. If y_cnt != 0 or x_cnt != 0 at that point, set line_err.
- Short line: line_valid falls while x_cnt != 0 -> set line_err, clear x_cnt. The line is not tlast-terminated, and y_cnt is unchanged.
- Long line: acc after tlast within the same line_valid high period -> pixel dropped, line_err set. No second tlast is emitted.
- FIFO:
  - Each entry is 3*DW+2 bits.
  - Write occurs the same cycle as acc. First visibility on tvalid is the next cycle (1-cycle latency).
  - Read when tvalid & tready.
  - Outputs come from the registered head of the FIFO. They are stable while tvalid & !tready (AXIS rule).
- Full: push when count==FIFO_DEPTH and no pop in the same cycle -> pixel dropped, overflow=1, FSM -> DROP. Push with a simultaneous pop while full is accepted; count is unchanged.
- Empty: tvalid=0; tdata, tuser and tlast are don't-care but held at their last value.
- Sticky flags clear only on reset.
- Size registers are sampled continuously. Changing them mid-frame is unsupported; behaviour is defined only by the counter compare rules above.

Test Plan:
- x_size_m1=3, y_size_m1=1; 4x2 frame, tready=1 -> 8 beats; tuser on beat 0 only; tlast on beats 3 and 7; frame_done pulses once; flags stay 0.
- Same frame, tready toggled 1/0 every cycle, FIFO_DEPTH=16 -> identical 8-beat sequence; data stable while stalled; overflow=0.
- x_size_m1=31, tready=0 for an entire 32-pixel line -> 16 beats held; overflow=1 on pixel 17; rest of frame dropped. Next frame's first beat after tready=1 has tuser=1.
- Line 0 has 3 pixels with x_size_m1=3 -> line_err=1, no tlast on beat 2. Line 1 has 4 pixels -> tlast on its 4th pixel.
- frame_valid drops after line 0 with y_size_m1=1 -> line_err=1, FSM returns to WAIT_SOF. Next frame beat 0 has tuser=1.
- resetn low for 1 cycle mid-line with FIFO holding 5 beats -> next cycle tvalid=0, flags 0. Pixels ignored until a new frame_valid rising edge.
